// File: rtl/patch_embed_pingpong_if.sv
// Purpose: bundles the write-beat, read and bank-handoff signals of the
//   ping-pong patch-embedding store into one interface.
// Ports (signals):
//   i_data_valid/i_spikes/i_wr_last -> write beat from upstream
//   o_wr_ready                      <- write bank free
//   i_rd_en/i_rd_addr               -> read request into current read bank
//   o_rd_data/o_rd_valid            <- read result, two cycles after request
//   o_rd_bank_valid/o_frame_len     <- read bank status
//   i_rd_release                    -> reader hands read bank back
//   o_overflow                      <- sticky error flag
// Modports: master drives requests (upstream/reader), slave is the store.
interface patch_embed_pingpong_if #(
  parameter int LANES  = 32,
  parameter int NUM_IN = 2,
  parameter int SUM_W  = 2,
  parameter int ADDR_W = 12
);
  logic                      i_data_valid;
  logic [NUM_IN*LANES-1:0]   i_spikes;
  logic                      i_wr_last;
  logic                      o_wr_ready;
  logic                      i_rd_en;
  logic [ADDR_W-1:0]         i_rd_addr;
  logic [LANES*SUM_W-1:0]    o_rd_data;
  logic                      o_rd_valid;
  logic                      o_rd_bank_valid;
  logic [ADDR_W:0]           o_frame_len;
  logic                      i_rd_release;
  logic                      o_overflow;

  modport master (
    output i_data_valid, i_spikes, i_wr_last, i_rd_en, i_rd_addr, i_rd_release,
    input  o_wr_ready, o_rd_data, o_rd_valid, o_rd_bank_valid, o_frame_len, o_overflow
  );

  modport slave (
    input  i_data_valid, i_spikes, i_wr_last, i_rd_en, i_rd_addr, i_rd_release,
    output o_wr_ready, o_rd_data, o_rd_valid, o_rd_bank_valid, o_frame_len, o_overflow
  );
endinterface

// File: rtl/patch_embed_pingpong.sv
// Purpose: per lane, counts set spikes across NUM_IN input planes and stores the
//   LANES x SUM_W sum word into one of two RAM banks. The writer fills one bank
//   (one frame) while the reader consumes the other; banks are handed over with
//   a commit (last beat) / release handshake. Overflow is flagged when a beat is
//   dropped for lack of a free bank or a frame is force-committed at DEPTH.
// Ports:
//   s_clk  clock
//   s_rst  synchronous reset, active-high
//   bus    patch_embed_pingpong_if.slave (write beats, reads, handoff, status)
module patch_embed_pingpong #(
  parameter int LANES  = 32,
  parameter int NUM_IN = 2,
  parameter int SUM_W  = 2,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  patch_embed_pingpong_if.slave bus
);
  localparam int WORD_W = LANES * SUM_W;
  localparam int LEN_W  = ADDR_W + 1;

  if (SUM_W < $clog2(NUM_IN + 1)) begin : g_sum_w_check
    $error("patch_embed_pingpong: SUM_W too narrow to hold a sum of NUM_IN spikes");
  end
  if ((1 << ADDR_W) < DEPTH) begin : g_addr_w_check
    $error("patch_embed_pingpong: ADDR_W too narrow for DEPTH");
  end

  // Control state and its next-state values.
  logic                        wr_bank_r, wr_bank_s;
  logic                        rd_bank_r, rd_bank_s;
  logic [ADDR_W-1:0]           wr_ptr_r, wr_ptr_s;
  logic [1:0]                  bank_full_r, bank_full_s;
  logic [1:0][LEN_W-1:0]       len_r, len_s;
  logic                        overflow_r, overflow_s;

  // Write stage (one cycle between accept and RAM write).
  logic                        ws_valid_r;
  logic                        ws_last_r;
  logic                        ws_bank_r;
  logic [ADDR_W-1:0]           ws_addr_r;
  logic [WORD_W-1:0]           ws_sum_r;

  // Read pipeline: RAM register then output register.
  logic [WORD_W-1:0]           mem_r [2*DEPTH];
  logic [WORD_W-1:0]           rd_q_r;
  logic                        rd_q_valid_r;
  logic [WORD_W-1:0]           rd_data_r;
  logic                        rd_valid_r;

  logic [WORD_W-1:0]           sum_s;
  logic                        accept_s, drop_s, at_end_s, last_s, release_s, commit_s;

  assign accept_s  = bus.i_data_valid && !bank_full_r[wr_bank_r];
  assign drop_s    = bus.i_data_valid &&  bank_full_r[wr_bank_r];
  assign at_end_s  = (wr_ptr_r == ADDR_W'(DEPTH - 1));
  assign last_s    = bus.i_wr_last || at_end_s;
  assign release_s = bus.i_rd_release && bank_full_r[rd_bank_r];
  // The bank becomes readable one cycle after its last beat, when that beat's RAM write lands.
  assign commit_s  = ws_valid_r && ws_last_r;

  // Per-lane popcount across the input planes; SUM_W is wide enough that this never wraps.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        sum_s[k*SUM_W +: SUM_W] = sum_s[k*SUM_W +: SUM_W] + SUM_W'(bus.i_spikes[j*LANES+k]);
      end
    end
  end

  // Next-state logic for bank pointers, fill flags, frame lengths and overflow.
  always_comb begin
    wr_bank_s   = wr_bank_r;
    wr_ptr_s    = wr_ptr_r;
    rd_bank_s   = rd_bank_r;
    bank_full_s = bank_full_r;
    len_s       = len_r;
    overflow_s  = overflow_r;
    if (accept_s) begin
      if (last_s) begin
        wr_bank_s = ~wr_bank_r;
        wr_ptr_s  = '0;
      end else begin
        wr_ptr_s  = wr_ptr_r + ADDR_W'(1);
      end
      if (at_end_s && !bus.i_wr_last) begin
        overflow_s = 1'b1;
      end else begin
        overflow_s = overflow_r | drop_s;
      end
    end else begin
      overflow_s = overflow_r | drop_s;
    end
    // Commit and release never target the same bank, so both may apply together.
    if (commit_s) begin
      bank_full_s[ws_bank_r] = 1'b1;
      len_s[ws_bank_r]       = {1'b0, ws_addr_r} + LEN_W'(1);
    end else begin
      len_s = len_r;
    end
    if (release_s) begin
      bank_full_s[rd_bank_r] = 1'b0;
      rd_bank_s              = ~rd_bank_r;
    end else begin
      rd_bank_s              = rd_bank_r;
    end
  end

  // Control state register.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      wr_ptr_r     <= '0;
      bank_full_r  <= 2'b00;
      len_r        <= '0;
      overflow_r   <= 1'b0;
      rd_q_valid_r <= 1'b0;
      rd_valid_r   <= 1'b0;
      rd_data_r    <= '0;
    end else begin
      wr_bank_r    <= wr_bank_s;
      rd_bank_r    <= rd_bank_s;
      wr_ptr_r     <= wr_ptr_s;
      bank_full_r  <= bank_full_s;
      len_r        <= len_s;
      overflow_r   <= overflow_s;
      rd_q_valid_r <= bus.i_rd_en;
      rd_valid_r   <= rd_q_valid_r;
      if (rd_q_valid_r) begin
        rd_data_r  <= rd_q_r;
      end
    end
  end

  // Write stage register: captures the accepted beat for next cycle's RAM write.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      ws_valid_r <= 1'b0;
      ws_last_r  <= 1'b0;
      ws_bank_r  <= 1'b0;
      ws_addr_r  <= '0;
      ws_sum_r   <= '0;
    end else begin
      ws_valid_r <= accept_s;
      ws_last_r  <= last_s;
      ws_bank_r  <= wr_bank_r;
      ws_addr_r  <= wr_ptr_r;
      ws_sum_r   <= sum_s;
    end
  end

  // Two-bank RAM: bank select is the address MSB; contents are deliberately not reset.
  always_ff @(posedge s_clk) begin
    if (ws_valid_r) begin
      mem_r[{ws_bank_r, ws_addr_r}] <= ws_sum_r;
    end
    if (bus.i_rd_en) begin
      rd_q_r <= mem_r[{rd_bank_r, bus.i_rd_addr}];
    end
  end

  assign bus.o_wr_ready      = !bank_full_r[wr_bank_r];
  assign bus.o_rd_bank_valid = bank_full_r[rd_bank_r];
  assign bus.o_frame_len     = len_r[rd_bank_r];
  assign bus.o_rd_data       = rd_data_r;
  assign bus.o_rd_valid      = rd_valid_r;
  assign bus.o_overflow      = overflow_r;
endmodule
